// File: rtl/regport_arbiter.sv
// Four read ports sharing one single-read-port register SRAM through per-port
// data latches, refilled one at a time by a round-robin IDLE/READ engine.
module regport_arbiter #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [4*AW-1:0] addr,
  input  logic            flush,
  output logic [3:0]      rd_valid,
  output logic [4*DW-1:0] rd,
  output logic [AW-1:0]   sram_ra,
  input  logic [DW-1:0]   sram_rd,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [DW-1:0]   wd,
  output logic            busy
);

  typedef enum logic {IDLE, READ} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      ptr_reg, sel_reg;
  logic [AW-1:0]   ra_reg;
  logic [DW-1:0]   l_rd   [4];
  logic [AW-1:0]   l_addr [4];
  logic            l_vld  [4];
  logic [AW-1:0]   port_addr [4];
  logic [3:0]      missing;
  logic            any_miss;
  logic [7:0]      miss_dbl;
  logic [3:0]      miss_rot;
  logic [1:0]      offset;
  logic [1:0]      winner;
  logic            fwd_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      assign port_addr[gi]        = addr[gi*AW +: AW];
      assign rd_valid[gi]         = !req[gi] | (l_vld[gi] & (l_addr[gi] == port_addr[gi]));
      assign rd[gi*DW +: DW]      = l_rd[gi];
    end
  endgenerate

  assign missing  = req & ~rd_valid;
  assign any_miss = |missing;
  assign sram_ra  = ra_reg;
  assign fwd_hit  = we && (wa == ra_reg);

  // Rotate the miss vector so bit 0 is the port at ptr; first set bit wins.
  always_comb begin
    miss_dbl = {missing, missing};
    miss_rot = miss_dbl[ptr_reg +: 4];
    offset   = 2'd0;
    if (miss_rot[0])      offset = 2'd0;
    else if (miss_rot[1]) offset = 2'd1;
    else if (miss_rot[2]) offset = 2'd2;
    else if (miss_rot[3]) offset = 2'd3;
    winner = ptr_reg + offset;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg == READ);
    case (state_reg)
      IDLE:    if (any_miss) state_next = READ;
      READ:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      sel_reg   <= 2'd0;
      ra_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_miss) begin
        ra_reg  <= port_addr[winner];
        sel_reg <= winner;
      end
      if (state_reg == READ) ptr_reg <= sel_reg + 2'd1;
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_latch
      logic fill;
      assign fill = (state_reg == READ) && (sel_reg == 2'(gi));

      // A fill overrides the coherence update; flush overrides the fill's valid.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          l_rd[gi]   <= '0;
          l_addr[gi] <= '0;
          l_vld[gi]  <= 1'b0;
        end else begin
          if (fill) begin
            l_rd[gi]   <= fwd_hit ? wd : sram_rd;
            l_addr[gi] <= ra_reg;
          end else if (l_vld[gi] && we && (wa == l_addr[gi])) begin
            l_rd[gi] <= wd;
          end
          if (flush)     l_vld[gi] <= 1'b0;
          else if (fill) l_vld[gi] <= 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regport_arbiter.sv
// Directed and randomized checks of regport_arbiter against a transaction-level
// model of the port latches and the pending SRAM fill.
module tb_regport_arbiter;
  localparam int AW = 8;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [4*AW-1:0] addr;
  logic            flush;
  logic [3:0]      rd_valid;
  logic [4*DW-1:0] rd;
  logic [AW-1:0]   sram_ra;
  logic [DW-1:0]   sram_rd;
  logic            we;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   wd;
  logic            busy;

  logic [DW-1:0] mem [256];
  assign sram_rd = mem[sram_ra];

  regport_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .flush(flush),
    .rd_valid(rd_valid), .rd(rd), .sram_ra(sram_ra), .sram_rd(sram_rd),
    .we(we), .wa(wa), .wd(wd), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each port's cached copy, plus at most one outstanding fill.
  logic [DW-1:0] m_rd  [4];
  logic [AW-1:0] m_tag [4];
  bit            m_vld [4];
  bit            m_busy;
  int            m_sel, m_ptr;
  logic [AW-1:0] m_ra;

  function automatic logic [AW-1:0] pa(int i);
    return addr[i*AW +: AW];
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = !req[i] || (m_vld[i] && m_tag[i] == pa(i));
    return v;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_rd[i] = '0; m_tag[i] = '0; m_vld[i] = 0;
    end
    m_busy = 0; m_sel = 0; m_ptr = 0; m_ra = '0;
  endtask

  task automatic check_all();
    logic [4*DW-1:0] exp_rd;
    for (int i = 0; i < 4; i++) exp_rd[i*DW +: DW] = m_rd[i];
    chk("busy", busy, m_busy);
    chk("sram_ra", sram_ra, m_ra);
    chk("rd", rd, exp_rd);
    chk("rd_valid", rd_valid, exp_valid());
  endtask

  task automatic cycle();
    logic [DW-1:0] n_rd  [4];
    logic [AW-1:0] n_tag [4];
    bit            n_vld [4];
    bit            n_busy;
    int            n_sel, n_ptr;
    logic [AW-1:0] n_ra;
    logic [3:0]    miss;
    bit            found;
    miss = req & ~exp_valid();
    for (int i = 0; i < 4; i++) begin
      n_rd[i] = m_rd[i]; n_tag[i] = m_tag[i]; n_vld[i] = m_vld[i];
      if (m_vld[i] && we && wa == m_tag[i]) n_rd[i] = wd;
    end
    n_busy = m_busy; n_sel = m_sel; n_ptr = m_ptr; n_ra = m_ra;
    if (m_busy) begin
      n_rd[m_sel]  = (we && wa == m_ra) ? wd : mem[m_ra];
      n_tag[m_sel] = m_ra;
      n_vld[m_sel] = 1;
      n_ptr        = (m_sel + 1) % 4;
      n_busy       = 0;
    end else begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && miss[(m_ptr + k) % 4]) begin
          found  = 1;
          n_sel  = (m_ptr + k) % 4;
          n_ra   = pa(n_sel);
          n_busy = 1;
        end
      end
    end
    if (flush) for (int i = 0; i < 4; i++) n_vld[i] = 0;
    @(posedge clk);
    #1;
    if (we) mem[wa] = wd;
    if (reset) model_clear();
    else begin
      for (int i = 0; i < 4; i++) begin
        m_rd[i] = n_rd[i]; m_tag[i] = n_tag[i]; m_vld[i] = n_vld[i];
      end
      m_busy = n_busy; m_sel = n_sel; m_ptr = n_ptr; m_ra = n_ra;
    end
    check_all();
  endtask

  task automatic set_addr(int i, int a);
    addr[i*AW +: AW] = AW'(a);
  endtask

  initial begin
    int fill_cyc [4];
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    reset = 1; req = 0; addr = '0; flush = 0; we = 0; wa = '0; wd = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ra", sram_ra, 0);
    chk("rst_rd", rd, 0);
    chk("rst_valid_noreq", rd_valid, 4'hF);
    req = 4'b0101;
    #1;
    chk("rst_valid_req", rd_valid, 4'b1010);
    req = 0;
    reset = 0;

    // Single miss latency
    mem[5] = 64'hAA;
    req = 4'b0001; set_addr(0, 5);
    cycle();
    chk("lat_ra", sram_ra, 5);
    chk("lat_busy", busy, 1);
    cycle();
    chk("lat_valid", rd_valid[0], 1);
    chk("lat_data", rd[63:0], 64'hAA);

    // Round-robin from a fresh pointer
    reset = 1; #2; reset = 0; model_clear();
    req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      set_addr(i, 10 + i);
      fill_cyc[i] = -1;
    end
    for (int c = 1; c <= 9; c++) begin
      cycle();
      for (int i = 0; i < 4; i++) if (fill_cyc[i] < 0 && rd_valid[i]) fill_cyc[i] = c;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr_fill_cycle_p%0d", i), 32'(fill_cyc[i]), 32'(2 + 2*i));
    set_addr(0, 30); set_addr(3, 33);
    cycle();
    chk("rr_ptr_wrap", sram_ra, 30);
    cycle();

    // Write coherence on a valid latch
    req = 4'b0001; set_addr(0, 5);
    cycle(); cycle();
    chk("coh_pre_valid", rd_valid[0], 1);
    we = 1; wa = 5; wd = 64'h1234;
    cycle();
    we = 0;
    chk("coh_data", rd[63:0], 64'h1234);
    chk("coh_busy", busy, 0);

    // Write forwarded into the fill
    mem[7] = 64'h7777;
    set_addr(0, 7);
    cycle();
    chk("fwd_busy", busy, 1);
    we = 1; wa = 7; wd = 64'hBEEF;
    cycle();
    we = 0;
    chk("fwd_data", rd[63:0], 64'hBEEF);
    chk("fwd_valid", rd_valid[0], 1);

    // Flush during the fill
    set_addr(0, 9);
    cycle();
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_valid", rd_valid[0], 0);
    chk("flush_busy", busy, 0);
    cycle();
    chk("flush_refill_busy", busy, 1);
    cycle();
    chk("flush_refill_valid", rd_valid[0], 1);
    chk("flush_refill_data", rd[63:0], mem[9]);

    // Reset mid-READ
    set_addr(0, 20);
    cycle();
    chk("rstmid_pre_busy", busy, 1);
    reset = 1;
    #1;
    model_clear();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rd", rd, 0);
    chk("rstmid_ra", sram_ra, 0);
    chk("rstmid_valid", rd_valid, 4'b1110);
    #1;
    reset = 0;
    cycle();

    // Randomized traffic over a small address set for frequent hits/sharing
    repeat (400) begin
      req = 4'($urandom);
      for (int i = 0; i < 4; i++) set_addr(i, int'($urandom_range(0, 7)));
      we = ($urandom_range(0, 3) == 0);
      wa = AW'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      flush = ($urandom_range(0, 15) == 0);
      cycle();
    end
    we = 0; flush = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
